// File: rtl/dds_pkg.sv
// Shared constants, state encoding and small helpers for the DDS
// configuration command parser.
package dds_pkg;

  // Frame delimiter and command codes
  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam logic [7:0] CMD_SET_FTW  = 8'h01;
  localparam logic [7:0] CMD_SET_AMP  = 8'h02;
  localparam logic [7:0] CMD_SET_MODE = 8'h03;

  // Payload length in bytes for each command
  localparam logic [2:0] LEN_SET_FTW  = 3'd4;
  localparam logic [2:0] LEN_SET_AMP  = 3'd1;
  localparam logic [2:0] LEN_SET_MODE = 3'd1;

  // Parser states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    COMMIT  = 3'd4
  } state_e;

  // Payload length for a command code; zero marks an unknown command
  function automatic logic [2:0] cmd_len(input logic [7:0] code);
    logic [2:0] len;
    case (code)
      CMD_SET_FTW:  len = LEN_SET_FTW;
      CMD_SET_AMP:  len = LEN_SET_AMP;
      CMD_SET_MODE: len = LEN_SET_MODE;
      default:      len = 3'd0;
    endcase
    return len;
  endfunction

  // Saturating 8-bit increment, never wraps past 8'hFF
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = 8'hFF;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dds_cfg_timeout.sv
// Inter-byte idle counter for the configuration parser. Clears on every
// received byte, counts while a frame is open, and is held at zero
// otherwise. expire_o fires on the cycle the count reaches TIMEOUT-1.
module dds_cfg_timeout #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 4) ? $clog2(TIMEOUT) : 2;
  // expiry is flagged while stepping from TIMEOUT-2 to TIMEOUT-1
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expire_s;

  // Next count and expiry detection
  always_comb begin
    cnt_d    = cnt_q;
    expire_s = 1'b0;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (run_i) begin
      if (cnt_q == CNT_PRE) begin
        expire_s = 1'b1;
        cnt_d    = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = expire_s;

endmodule

// File: rtl/dds_cfg_ctrl.sv
// Byte-level command parser that validates XOR-checksummed frames from the
// UART receiver and commits tuning word, amplitude and OOK mode to the DDS
// core atomically. Live registers only ever change on a fully valid frame.
module dds_cfg_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned FTW_W   = 32,
  parameter logic [31:0] FTW_RST = 32'h0100_0000,
  parameter logic [7:0]  AMP_RST = 8'hFF,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [FTW_W-1:0] ftw,
  output logic [7:0]       amp,
  output logic             ook_en,
  output logic             ook_inv,
  output logic             cfg_upd,
  output logic             cfg_err,
  output logic [7:0]       err_cnt,
  output logic             busy
);

  state_e           state_q,   state_d;
  logic [7:0]       cmd_q,     cmd_d;
  logic [2:0]       len_q,     len_d;
  logic [1:0]       idx_q,     idx_d;
  logic [7:0]       chk_q,     chk_d;
  logic [31:0]      shadow_q,  shadow_d;
  logic [FTW_W-1:0] ftw_q,     ftw_d;
  logic [7:0]       amp_q,     amp_d;
  logic             ook_en_q,  ook_en_d;
  logic             ook_inv_q, ook_inv_d;
  logic             cfg_upd_q, cfg_upd_d;
  logic             cfg_err_q, cfg_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             busy_q,    busy_d;

  logic             tmo_run_s;
  logic             tmo_expire_s;

  // The idle timer only runs while a frame is open and awaiting bytes
  assign tmo_run_s = (state_q == CMD) || (state_q == PAYLOAD) || (state_q == CHECK);

  dds_cfg_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (rx_valid),
    .run_i    (tmo_run_s),
    .expire_o (tmo_expire_s)
  );

  // Parser next-state, shadow assembly and live register commit
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    shadow_d  = shadow_q;
    ftw_d     = ftw_q;
    amp_d     = amp_q;
    ook_en_d  = ook_en_q;
    ook_inv_d = ook_inv_q;
    cfg_upd_d = 1'b0;
    cfg_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // anything other than the sync byte is silently discarded
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = CMD;
        end else begin
          state_d = IDLE;
        end
      end

      CMD: begin
        if (rx_valid) begin
          if (cmd_len(rx_data) != 3'd0) begin
            cmd_d    = rx_data;
            len_d    = cmd_len(rx_data);
            chk_d    = rx_data;
            idx_d    = 2'd0;
            shadow_d = 32'h0000_0000;
            state_d  = PAYLOAD;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (tmo_expire_s) begin
          cfg_err_d = 1'b1;
          shadow_d  = 32'h0000_0000;
          state_d   = IDLE;
        end else begin
          state_d = CMD;
        end
      end

      PAYLOAD: begin
        if (rx_valid) begin
          // little-endian: first payload byte lands in bits 7:0
          shadow_d[{idx_q, 3'b000} +: 8] = rx_data;
          chk_d = chk_q ^ rx_data;
          idx_d = idx_q + 2'd1;
          if ({1'b0, idx_q} == (len_q - 3'd1)) begin
            state_d = CHECK;
          end else begin
            state_d = PAYLOAD;
          end
        end else if (tmo_expire_s) begin
          cfg_err_d = 1'b1;
          shadow_d  = 32'h0000_0000;
          state_d   = IDLE;
        end else begin
          state_d = PAYLOAD;
        end
      end

      CHECK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            // The copy is scheduled on entry to COMMIT so the live value
            // and cfg_upd appear in the cycle right after the CHK strobe.
            case (cmd_q)
              CMD_SET_FTW: begin
                ftw_d = shadow_q[FTW_W-1:0];
              end
              CMD_SET_AMP: begin
                amp_d = shadow_q[7:0];
              end
              CMD_SET_MODE: begin
                ook_en_d  = shadow_q[0];
                ook_inv_d = shadow_q[1];
              end
              default: begin
                ftw_d = ftw_q;
              end
            endcase
            cfg_upd_d = 1'b1;
            state_d   = COMMIT;
          end else begin
            cfg_err_d = 1'b1;
            shadow_d  = 32'h0000_0000;
            state_d   = IDLE;
          end
        end else if (tmo_expire_s) begin
          cfg_err_d = 1'b1;
          shadow_d  = 32'h0000_0000;
          state_d   = IDLE;
        end else begin
          state_d = CHECK;
        end
      end

      COMMIT: begin
        // any byte arriving in this cycle is dropped
        state_d = IDLE;
      end

      default: begin
        shadow_d = 32'h0000_0000;
        state_d  = IDLE;
      end
    endcase
  end

  // Error counter and busy flag follow the parser decisions
  always_comb begin
    if (cfg_err_d) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
    busy_d = (state_d != IDLE);
  end

  // Parser state, shadow and live configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= 8'h00;
      len_q     <= 3'd0;
      idx_q     <= 2'd0;
      chk_q     <= 8'h00;
      shadow_q  <= 32'h0000_0000;
      ftw_q     <= FTW_RST[FTW_W-1:0];
      amp_q     <= AMP_RST;
      ook_en_q  <= 1'b1;
      ook_inv_q <= 1'b0;
      cfg_upd_q <= 1'b0;
      cfg_err_q <= 1'b0;
      err_cnt_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      shadow_q  <= shadow_d;
      ftw_q     <= ftw_d;
      amp_q     <= amp_d;
      ook_en_q  <= ook_en_d;
      ook_inv_q <= ook_inv_d;
      cfg_upd_q <= cfg_upd_d;
      cfg_err_q <= cfg_err_d;
      err_cnt_q <= err_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign ftw     = ftw_q;
  assign amp     = amp_q;
  assign ook_en  = ook_en_q;
  assign ook_inv = ook_inv_q;
  assign cfg_upd = cfg_upd_q;
  assign cfg_err = cfg_err_q;
  assign err_cnt = err_cnt_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// Testbench for dds_cfg_ctrl: directed byte streams, a frame-level
// reference model, a per-cycle compare process and literal spot checks.
module tb_dds_cfg_ctrl;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] ftw;
  logic [7:0]  amp;
  logic        ook_en;
  logic        ook_inv;
  logic        cfg_upd;
  logic        cfg_err;
  logic [7:0]  err_cnt;
  logic        busy;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  dds_cfg_ctrl #(
    .FTW_W   (32),
    .FTW_RST (32'h0100_0000),
    .AMP_RST (8'hFF),
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ftw      (ftw),
    .amp      (amp),
    .ook_en   (ook_en),
    .ook_inv  (ook_inv),
    .cfg_upd  (cfg_upd),
    .cfg_err  (cfg_err),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (frame level) ----------------
  logic [31:0] m_ftw    = 32'h0100_0000;
  logic [7:0]  m_amp    = 8'hFF;
  logic        m_en     = 1'b1;
  logic        m_inv    = 1'b0;
  logic        m_upd    = 1'b0;
  logic        m_err    = 1'b0;
  int          m_errcnt = 0;
  bit          m_in_frame = 1'b0;
  bit          m_commit   = 1'b0;
  int          m_idle     = 0;
  logic [7:0]  m_frm[$];

  function automatic int len_of(input logic [7:0] c);
    if (c == 8'h01) return 4;
    else if (c == 8'h02) return 1;
    else if (c == 8'h03) return 1;
    else return 0;
  endfunction

  task automatic model_step();
    logic [7:0]  x;
    logic [31:0] val;
    int          n;
    if (!rst_n) begin
      m_ftw = 32'h0100_0000; m_amp = 8'hFF; m_en = 1'b1; m_inv = 1'b0;
      m_upd = 1'b0; m_err = 1'b0; m_errcnt = 0;
      m_in_frame = 1'b0; m_commit = 1'b0; m_idle = 0; m_frm.delete();
    end else begin
      m_upd = 1'b0;
      m_err = 1'b0;
      if (m_commit) begin
        m_commit = 1'b0;               // byte in the commit cycle is lost
      end else if (m_in_frame) begin
        if (rx_valid) begin
          m_idle = 0;
          m_frm.push_back(rx_data);
          n = m_frm.size();
          if (n == 1) begin
            if (len_of(m_frm[0]) == 0) begin
              m_err = 1'b1; m_in_frame = 1'b0;
            end
          end else if (n == len_of(m_frm[0]) + 2) begin
            x = 8'h00;
            for (int i = 0; i < n - 1; i++) x = x ^ m_frm[i];
            if (x == m_frm[n-1]) begin
              val = 32'h0;
              for (int i = 0; i < len_of(m_frm[0]); i++) val[8*i +: 8] = m_frm[1+i];
              if (m_frm[0] == 8'h01) m_ftw = val;
              else if (m_frm[0] == 8'h02) m_amp = val[7:0];
              else begin m_en = val[0]; m_inv = val[1]; end
              m_upd = 1'b1; m_commit = 1'b1;
            end else begin
              m_err = 1'b1;
            end
            m_in_frame = 1'b0;
          end
        end else begin
          m_idle++;
          if (m_idle == TMO - 1) begin
            m_err = 1'b1; m_in_frame = 1'b0;
          end
        end
      end else if (rx_valid && rx_data == 8'hA5) begin
        m_in_frame = 1'b1; m_frm.delete(); m_idle = 0;
      end
      if (m_err && m_errcnt < 255) m_errcnt++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("ftw", ftw, m_ftw);
        chk("amp", {24'h0, amp}, {24'h0, m_amp});
        chk("ook_en", {31'h0, ook_en}, {31'h0, m_en});
        chk("ook_inv", {31'h0, ook_inv}, {31'h0, m_inv});
        chk("cfg_upd", {31'h0, cfg_upd}, {31'h0, m_upd});
        chk("cfg_err", {31'h0, cfg_err}, {31'h0, m_err});
        chk("err_cnt", {24'h0, err_cnt}, 32'(m_errcnt));
        chk("busy", {31'h0, busy}, {31'h0, (m_in_frame || m_commit)});
        chk("upd_err_excl", {31'h0, (cfg_upd & cfg_err)}, 32'h0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] fq[$];

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // one idle cycle after each byte; returns one cycle after the last strobe
  task automatic send_fq();
    foreach (fq[i]) begin
      send(fq[i]);
      idle(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ftw", ftw, 32'h0100_0000);
    chk("rst_amp", {24'h0, amp}, 32'h0000_00FF);
    chk("rst_mode", {30'h0, ook_inv, ook_en}, 32'h1);
    chk("rst_errcnt_busy", {23'h0, busy, err_cnt}, 32'h0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    idle(2);

    // SET_FTW
    fq = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_fq();
    chk("ftw_upd_pulse", {31'h0, cfg_upd}, 32'h1);
    chk("ftw_value", ftw, 32'h1234_5678);
    chk("ftw_amp_kept", {24'h0, amp}, 32'h0000_00FF);
    chk("model_ftw", m_ftw, 32'h1234_5678);
    idle(1);
    chk("ftw_upd_one_cycle", {31'h0, cfg_upd}, 32'h0);

    // bad checksum then good SET_AMP
    fq = '{8'hA5, 8'h02, 8'h80, 8'h83};
    send_fq();
    chk("badchk_err", {31'h0, cfg_err}, 32'h1);
    chk("badchk_cnt", {24'h0, err_cnt}, 32'h1);
    chk("badchk_amp", {24'h0, amp}, 32'h0000_00FF);
    fq = '{8'hA5, 8'h02, 8'h80, 8'h82};
    send_fq();
    chk("amp_value", {24'h0, amp}, 32'h0000_0080);
    chk("amp_upd", {31'h0, cfg_upd}, 32'h1);

    // junk before sync, unknown command
    fq = '{8'h00, 8'hA5, 8'h07};
    send_fq();
    chk("unk_err", {31'h0, cfg_err}, 32'h1);
    chk("unk_cnt", {24'h0, err_cnt}, 32'h2);
    chk("unk_busy", {31'h0, busy}, 32'h0);
    fq = '{8'hA5, 8'h03, 8'h03, 8'h00};
    send_fq();
    chk("mode_value", {30'h0, ook_inv, ook_en}, 32'h3);

    // 0xA5 as payload, then a byte landing in the commit cycle is dropped
    fq = '{8'hA5, 8'h02, 8'hA5};
    send_fq();
    send(8'hA7);
    send(8'hA5);
    idle(1);
    fq = '{8'h02, 8'h11, 8'h13};
    send_fq();
    idle(2);
    chk("a5_payload_amp", {24'h0, amp}, 32'h0000_00A5);
    chk("commit_drop_busy", {31'h0, busy}, 32'h0);

    // timeout after A5 01 AA
    fq = '{8'hA5, 8'h01};
    send_fq();
    send(8'hAA);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      idle(1);
      if (cfg_err) begin
        k = c;
        break;
      end
    end
    chk("tmo_latency", 32'(k), 32'd16);
    chk("tmo_cnt", {24'h0, err_cnt}, 32'h3);
    chk("tmo_ftw_kept", ftw, 32'h1234_5678);
    idle(1);
    chk("tmo_idle", {31'h0, busy}, 32'h0);
    fq = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
    send_fq();
    chk("post_tmo_ftw", ftw, 32'hDEAD_BEEF);

    // saturation
    for (int i = 0; i < 256; i++) begin
      send(8'hA5);
      send(8'h07);
    end
    idle(2);
    chk("errcnt_sat", {24'h0, err_cnt}, 32'h0000_00FF);

    // reset mid-frame
    fq = '{8'hA5, 8'h01, 8'h11};
    send_fq();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ftw", ftw, 32'h0100_0000);
    chk("arst_amp", {24'h0, amp}, 32'h0000_00FF);
    chk("arst_mode", {30'h0, ook_inv, ook_en}, 32'h1);
    chk("arst_cnt_busy", {23'h0, busy, err_cnt}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    fq = '{8'hA5, 8'h02, 8'h40, 8'h42};
    send_fq();
    chk("post_rst_amp", {24'h0, amp}, 32'h0000_0040);
    idle(3);

    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dds_cfg_ctrl.md
Name: dds_cfg_ctrl

Overview:
Byte-level command parser that configures the OOK DDS from the UART receive path. It consumes received bytes and validates framed commands with an XOR checksum. It commits the frequency tuning word, amplitude and OOK mode atomically to the DDS core, so the live DDS configuration only changes on a fully valid frame. It sits between the UART receiver and the DDS phase accumulator/DAC datapath inside the top level.

Parameters:
FTW_W, 32, tuning word width (24..32); the payload always carries 4 bytes, and the low FTW_W bits are used.
FTW_RST, 32'h0100_0000, tuning word after reset (truncated to FTW_W).
AMP_RST, 8'hFF, amplitude after reset.
TIMEOUT, 100000, idle cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte, valid only when rx_valid=1
rx_valid  in  1  single-cycle strobe per received byte
ftw  out  FTW_W  live frequency tuning word
amp  out  8  live amplitude scale
ook_en  out  1  1 = OOK keying applied to output
ook_inv  out  1  1 = invert ook_data polarity
cfg_upd  out  1  one-cycle pulse when a frame is committed
cfg_err  out  1  one-cycle pulse on checksum error, unknown command or timeout
err_cnt  out  8  saturating error counter
busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets: ftw=FTW_RST, amp=AMP_RST, ook_en=1, ook_inv=0, cfg_upd=0, cfg_err=0, err_cnt=0, busy=0, state=IDLE, shadow regs=0.
- Frame format: SYNC(0xA5), CMD, payload (LEN bytes, little-endian), CHK. CHK = XOR of CMD and all payload bytes.
- Commands:
  - 0x01 SET_FTW, LEN=4.
  - 0x02 SET_AMP, LEN=1.
  - 0x03 SET_MODE, LEN=1; bit0 = ook_en, bit1 = ook_inv, bits 7:2 ignored.
- Bytes are acted on only in cycles with rx_valid=1.
- FSM transitions:
  - IDLE: byte==0xA5 -> CMD. Any other byte is silently dropped, with no error.
  - CMD: known code -> latch cmd, load LEN, chk=byte, byte index=0 -> PAYLOAD. Unknown code -> cfg_err pulse -> IDLE.
  - PAYLOAD: store the byte into shadow[index*8 +: 8], chk ^= byte, index++. When index reaches LEN-1 on the stored byte -> CHECK.
  - CHECK: byte==chk -> COMMIT; otherwise cfg_err pulse -> IDLE.
  - COMMIT (one cycle, entered regardless of rx_valid): copy shadow to the live register selected by cmd, pulse cfg_upd -> IDLE.
- Latency: the live output changes, and cfg_upd is high, in the cycle after the CHK byte strobe. cfg_err is high in the cycle after the offending byte strobe.
- A byte arriving during COMMIT is dropped. The UART byte period makes this impossible in practice, and the bench checks it anyway.
- 0xA5 is not special once a frame has started. It is treated as data/CMD/CHK according to the current state, and there is no resync mid-frame.
- Timeout:
  - The counter clears on every rx_valid and increments while state is CMD, PAYLOAD or CHECK.
  - When it reaches TIMEOUT-1: cfg_err pulse, shadow discarded, state -> IDLE.
  - The counter is held at 0 in IDLE.
- err_cnt: +1 per cfg_err pulse, saturates at 8'hFF and never wraps.
- Live registers are never partially updated. A failed or aborted frame leaves ftw, amp and mode unchanged.
- Reset asserted mid-frame returns everything to reset values immediately, and the partial frame is lost.
- cfg_upd and cfg_err are never high in the same cycle.

Decomposition:
- Shared package dds_pkg holds:
  - SYNC_BYTE = 8'hA5.
  - CMD_SET_FTW = 8'h01, CMD_SET_AMP = 8'h02, CMD_SET_MODE = 8'h03.
  - LEN values per command.
  - State enum (IDLE, CMD, PAYLOAD, CHECK, COMMIT).
- One sub-module, dds_cfg_timeout: loadable/clearable counter with an expiry flag, parameterised by TIMEOUT.
- The parser FSM and register bank stay in dds_cfg_ctrl.

Test Plan:
- After reset -> ftw=0x01000000, amp=0xFF, ook_en=1, ook_inv=0, err_cnt=0, busy=0.
- Bytes A5 01 78 56 34 12 09 -> ftw=0x12345678 and cfg_upd high for 1 cycle, in the cycle after the 09 strobe; amp and mode unchanged.
- Bytes A5 02 80 83 (bad CHK, expected 82) -> cfg_err pulse, err_cnt=1, amp stays 0xFF. Then A5 02 80 82 -> amp=0x80, cfg_upd pulse.
- Bytes 00 A5 07 -> 00 ignored, 07 unknown command -> cfg_err, err_cnt+1, busy=0. Then A5 03 03 00 -> ook_en=1, ook_inv=1.
- TIMEOUT=16, bytes A5 01 AA then silence -> cfg_err exactly 16 cycles after the AA strobe, state IDLE, ftw unchanged. A subsequent valid frame is accepted.
- Force 256 bad frames -> err_cnt saturates at 0xFF. rst_n pulsed low mid-frame (after A5 01 11) -> all outputs return to reset values asynchronously.
